// File: rtl/irrigation_sensor_frontend_if.sv
// Sensor bundle between the field-input frontend and the irrigation controller.
interface irrigation_sensor_frontend_if;
  logic       enable;
  logic       raw_low_water_level;
  logic       raw_mid_water_level;
  logic       raw_high_water_level;
  logic       raw_earth_humidity;
  logic       raw_air_humidity;
  logic       raw_low_temperature;
  logic       low_water_level;
  logic       mid_water_level;
  logic       high_water_level;
  logic       earth_humidity;
  logic       air_humidity;
  logic       low_temperature;
  logic [1:0] level_code;
  logic       sample_valid;
  logic       sensor_fault;

  // Frontend side: consumes raw field inputs, produces the clean snapshot
  modport master (
    input  enable,
    input  raw_low_water_level, raw_mid_water_level, raw_high_water_level,
    input  raw_earth_humidity, raw_air_humidity, raw_low_temperature,
    output low_water_level, mid_water_level, high_water_level,
    output earth_humidity, air_humidity, low_temperature,
    output level_code, sample_valid, sensor_fault
  );

  // Controller / stimulus side
  modport slave (
    output enable,
    output raw_low_water_level, raw_mid_water_level, raw_high_water_level,
    output raw_earth_humidity, raw_air_humidity, raw_low_temperature,
    input  low_water_level, mid_water_level, high_water_level,
    input  earth_humidity, air_humidity, low_temperature,
    input  level_code, sample_valid, sensor_fault
  );
endinterface

// File: rtl/irrigation_sensor_frontend.sv
// Synchronises and debounces six field inputs, then publishes periodic
// snapshots with a valid strobe and a persistent tank-level fault flag.
module irrigation_sensor_frontend #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned SAMPLE_PERIOD   = 1000,
  parameter int unsigned FAULT_LIMIT     = 3
) (
  input  logic                          clock,
  input  logic                          reset_n,
  irrigation_sensor_frontend_if.master  bus
);

  localparam int unsigned NCH       = 6;
  localparam int unsigned DB_W      = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned WARM_LAST = DEBOUNCE_CYCLES + 1;
  localparam int unsigned PER_LAST  = SAMPLE_PERIOD - 1;
  localparam int unsigned TMR_MAX   = (WARM_LAST > PER_LAST) ? WARM_LAST : PER_LAST;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);
  localparam int unsigned FLT_W     = $clog2(FAULT_LIMIT + 1);

  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_WARM  = TMR_W'(WARM_LAST);
  localparam logic [TMR_W-1:0] T_PER   = TMR_W'(PER_LAST);
  localparam logic [FLT_W-1:0] FLT_LIM = FLT_W'(FAULT_LIMIT);

  typedef enum logic [1:0] {S_OFF, S_WARMUP, S_RUN} state_t;

  // Channel order: 0 low, 1 mid, 2 high, 3 earth, 4 air, 5 low temperature
  logic [NCH-1:0]  w_raw;
  logic [NCH-1:0]  r_sync1;
  logic [NCH-1:0]  r_sync2;
  logic [NCH-1:0]  r_deb;
  logic [DB_W-1:0] r_db_cnt [NCH];

  state_t          r_state;
  state_t          w_state_next;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timer_next;
  logic            w_snap;

  logic [NCH-1:0]  r_clean;
  logic [1:0]      r_level_code;
  logic            r_sample_valid;
  logic            r_sensor_fault;
  logic [FLT_W-1:0] r_fault_cnt;
  logic [FLT_W-1:0] w_fault_inc;
  logic            w_consistent;
  logic [1:0]      w_level;

  assign w_raw = {bus.raw_low_temperature, bus.raw_air_humidity, bus.raw_earth_humidity,
                  bus.raw_high_water_level, bus.raw_mid_water_level, bus.raw_low_water_level};

  // Two-flop synchronisers plus per-channel debounce counters; active in every state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      for (int i = 0; i < NCH; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NCH; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // FSM state and timer registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_OFF;
      r_timer <= '0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
    end
  end

  // Next state, timer and snapshot trigger; dropping enable wins over everything
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_snap       = 1'b0;
    if (!bus.enable) begin
      w_state_next = S_OFF;
      w_timer_next = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_next = S_WARMUP;
          w_timer_next = '0;
        end
        S_WARMUP: begin
          if (r_timer == T_WARM) begin
            w_state_next = S_RUN;
            w_timer_next = '0;
          end else begin
            w_timer_next = r_timer + TMR_W'(1);
          end
        end
        S_RUN: begin
          if (r_timer == T_PER) begin
            w_timer_next = '0;
            w_snap       = 1'b1;
          end else begin
            w_timer_next = r_timer + TMR_W'(1);
          end
        end
        default: begin
          w_state_next = S_OFF;
          w_timer_next = '0;
        end
      endcase
    end
  end

  // Level consistency and encoding of the debounced probes
  always_comb begin
    w_consistent = !((r_deb[2] && !r_deb[1]) || (r_deb[1] && !r_deb[0]) ||
                     (r_deb[2] && !r_deb[0]));
    if (r_deb[2])      w_level = 2'd3;
    else if (r_deb[1]) w_level = 2'd2;
    else if (r_deb[0]) w_level = 2'd1;
    else               w_level = 2'd0;
    w_fault_inc = (r_fault_cnt == FLT_LIM) ? r_fault_cnt : r_fault_cnt + FLT_W'(1);
  end

  // Snapshot registers, valid strobe and fault tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_clean        <= '0;
      r_level_code   <= '0;
      r_sample_valid <= 1'b0;
      r_sensor_fault <= 1'b0;
      r_fault_cnt    <= '0;
    end else begin
      r_sample_valid <= w_snap;
      if (!bus.enable) begin
        r_fault_cnt <= '0;
      end else if (w_snap) begin
        r_clean <= r_deb;
        if (w_consistent) begin
          r_level_code   <= w_level;
          r_fault_cnt    <= '0;
          r_sensor_fault <= 1'b0;
        end else begin
          r_fault_cnt <= w_fault_inc;
          if (w_fault_inc == FLT_LIM) r_sensor_fault <= 1'b1;
        end
      end
    end
  end

  assign bus.low_water_level  = r_clean[0];
  assign bus.mid_water_level  = r_clean[1];
  assign bus.high_water_level = r_clean[2];
  assign bus.earth_humidity   = r_clean[3];
  assign bus.air_humidity     = r_clean[4];
  assign bus.low_temperature  = r_clean[5];
  assign bus.level_code       = r_level_code;
  assign bus.sample_valid     = r_sample_valid;
  assign bus.sensor_fault     = r_sensor_fault;

endmodule
